encoder_8to3: RTL and testbench



---
 rtl/encoder_8to3_pkg.sv | 10 +
 rtl/encoder_8to3_prio.sv | 31 +++
 rtl/encoder_8to3.sv | 37 +++
 tb/tb_encoder_8to3.sv | 135 +++++++++++++
 4 files changed

// File: rtl/encoder_8to3_pkg.sv
// Width and reset constants shared by the 8-to-3 encoder files.
// No latency or backpressure; declarations only.
package encoder_8to3_pkg;

    localparam int ENC_IN_W  = 8;
    localparam int ENC_OUT_W = $clog2(ENC_IN_W);

    localparam logic [ENC_OUT_W-1:0] ENC_A_RST = '0;

endpackage

// File: rtl/encoder_8to3_prio.sv
// Combinational priority encoder: index of the highest set bit, plus any/multi flags.
// Zero latency; no backpressure, pure function of the input.
module encoder_8to3_prio
    import encoder_8to3_pkg::*;
(
    input  logic [ENC_IN_W-1:0]  Y,
    output logic [ENC_OUT_W-1:0] idx,
    output logic                 any,
    output logic                 multi
);

    logic found;

    // Scan from the top bit down; the first hit is the winner.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        for (int i = ENC_IN_W - 1; i >= 0; i--) begin
            if (!found && Y[i]) begin
                idx   = ENC_OUT_W'(i);
                found = 1'b1;
            end
        end
    end

    assign any = found;

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign multi = |(Y & (Y - ENC_IN_W'(1)));

endmodule

// File: rtl/encoder_8to3.sv
// Registered 8-to-3 priority encoder with valid and multi-hot flags.
// Latency 1 cycle; no backpressure, the output register samples every cycle.
module encoder_8to3
    import encoder_8to3_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [ENC_IN_W-1:0]  Y,
    output logic [ENC_OUT_W-1:0] A,
    output logic                 valid,
    output logic                 multi
);

    logic [ENC_OUT_W-1:0] idx_nxt;
    logic                 any_nxt;
    logic                 multi_nxt;

    encoder_8to3_prio u_prio (
        .Y     (Y),
        .idx   (idx_nxt),
        .any   (any_nxt),
        .multi (multi_nxt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            A     <= ENC_A_RST;
            valid <= 1'b0;
            multi <= 1'b0;
        end else begin
            A     <= idx_nxt;
            valid <= any_nxt;
            multi <= multi_nxt;
        end
    end

endmodule

// File: tb/tb_encoder_8to3.sv
// Self-checking bench for encoder_8to3: directed steps plus a random one-hot run.
module tb_encoder_8to3;

    logic       clk;
    logic       rst_n;
    logic [7:0] Y;
    logic [2:0] A;
    logic       valid;
    logic       multi;

    int checks = 0;
    int errors = 0;

    // Expected {A, valid, multi} for the value captured at the next edge.
    logic [4:0] sb[$];

    encoder_8to3 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .Y     (Y),
        .A     (A),
        .valid (valid),
        .multi (multi)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [4:0] model(input logic [7:0] y);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++)
            if (y[i]) idx = i[2:0];
        return {idx, |y, ($countones(y) > 1)};
    endfunction

    task automatic check(input string tag, input logic [4:0] exp);
        checks++;
        assert ({A, valid, multi} === exp) else begin
            errors++;
            $error("FAIL %s: got A=%0d valid=%b multi=%b, expected A=%0d valid=%b multi=%b",
                   tag, A, valid, multi, exp[4:2], exp[1], exp[0]);
        end
    endtask

    // At each falling edge: check the result of the previous input, then drive a new one.
    task automatic step(input string tag, input logic [7:0] y, input logic [4:0] exp);
        logic [4:0] e;
        @(negedge clk);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(tag, e);
        end
        Y = y;
        sb.push_back(exp);
    endtask

    initial begin
        logic [7:0] ry;
        logic [4:0] e;

        // Reset held with all inputs set: outputs must stay cleared across edges.
        rst_n = 1'b0;
        Y     = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("reset_hold", 5'b000_0_0);
        end

        // Release with Y=0; first edge loads index 0, valid 0.
        rst_n = 1'b1;
        Y     = 8'h00;
        sb.push_back(5'b000_0_0);

        // One-hot sweep; each step checks the previous value.
        step("sweep_00", 8'h01, 5'b000_1_0);
        step("sweep_01", 8'h02, 5'b001_1_0);
        step("sweep_02", 8'h04, 5'b010_1_0);
        step("sweep_04", 8'h08, 5'b011_1_0);
        step("sweep_08", 8'h10, 5'b100_1_0);
        step("sweep_10", 8'h20, 5'b101_1_0);
        step("sweep_20", 8'h40, 5'b110_1_0);
        step("sweep_40", 8'h80, 5'b111_1_0);

        // Multi-hot priority.
        step("sweep_80", 8'b0010_0100, 5'b101_1_1);
        step("multi_24", 8'hFF,        5'b111_1_1);
        step("multi_ff", 8'b0000_0011, 5'b001_1_1);

        // Zero versus bit 0.
        step("multi_03", 8'h00, 5'b000_0_0);
        step("zero",     8'h01, 5'b000_1_0);
        step("bit0",     8'h10, 5'b100_1_0);

        // Mid-stream asynchronous reset pulse between edges.
        @(posedge clk);
        #2;
        e = sb.pop_front();
        check("pre_reset", e);
        rst_n = 1'b0;
        #1;
        check("async_clear", 5'b000_0_0);
        sb.delete();
        @(negedge clk);
        check("reset_low_held", 5'b000_0_0);
        rst_n = 1'b1;
        sb.push_back(5'b100_1_0);

        step("after_release", 8'h20, 5'b101_1_0);
        step("post_reset_20", 8'h40, 5'b110_1_0);

        // Random one-hot stream, one new value per cycle.
        for (int n = 0; n < 200; n++) begin
            ry = 8'h01 << $urandom_range(0, 7);
            step("random", ry, model(ry));
        end

        // Drain the pipeline.
        while (sb.size() > 0) begin
            @(negedge clk);
            e = sb.pop_front();
            check("drain", e);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
